// File: rtl/uart_receiver.sv
// uart_receiver: 7-data/odd-parity/1-stop UART receive stage, mid-bit oversampled, ready/ack holding register.
// Optional feature macro: UART_RX_PARITY_CHECK_EN (parity_err computed when defined, tied 0 otherwise).
module uart_receiver #(
   parameter int OVERSAMPLE = 16,
   parameter int CNT_W      = 4
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       rx,
   input  logic       rx_en,
   input  logic       rd_ack,
   output logic [6:0] data_out,
   output logic       valid,
   output logic       rdy,
   output logic       busy,
   output logic       parity_err,
   output logic       frame_err,
   output logic       overrun
);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE/2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       idx, idx_nxt;
   logic [6:0]       shift, shift_nxt;
   logic             armed, armed_nxt;
   logic             complete;
   logic             rx_p0, rxs;
`ifdef UART_RX_PARITY_CHECK_EN
   logic             par_bit, par_nxt;

   function automatic logic parity_error(input logic [7:0] bits);
      return ~^bits;
   endfunction
`endif

   // stage p0/p1: two-flop synchronizer, idle-high reset
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         rx_p0 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         rx_p0 <= rx;
         rxs   <= rx_p0;
      end
   end

   // Arming is held off mid-frame so a line stuck low after a bad stop bit cannot start a phantom frame.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      shift_nxt = shift;
      armed_nxt = armed;
      complete  = 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
      par_nxt   = par_bit;
`endif
      if (rx_en) begin
         unique case (state)
            IDLE: begin
               if (armed && !rxs) begin
                  state_nxt = START;
                  cnt_nxt   = '0;
                  armed_nxt = 1'b0;
               end else if (rxs) begin
                  armed_nxt = 1'b1;
               end
            end
            START: begin
               if (cnt == HALF_LAST) begin
                  cnt_nxt = '0;
                  if (rxs) begin
                     state_nxt = IDLE;
                     armed_nxt = 1'b1;
                  end else begin
                     state_nxt = DATA;
                     idx_nxt   = 3'd0;
                  end
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt_nxt = '0;
                  idx_nxt = idx + 3'd1;
                  if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_CHECK_EN
                     par_nxt = rxs;
`endif
                     state_nxt = STOP;
                  end else begin
                     shift_nxt[idx] = rxs;
                  end
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == BIT_LAST) begin
                  complete  = 1'b1;
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
                  armed_nxt = rxs;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= 3'd0;
         armed <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
         armed <= armed_nxt;
      end
   end

   always_ff @(posedge clk) begin
      shift <= shift_nxt;
`ifdef UART_RX_PARITY_CHECK_EN
      par_bit <= par_nxt;
`endif
   end

   // stage p2: holding register and handshake; completion beats a same-cycle rd_ack
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         data_out  <= 7'd0;
         valid     <= 1'b0;
         rdy       <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         valid <= complete;
         if (complete) begin
            data_out  <= shift;
            frame_err <= ~rxs;
            rdy       <= 1'b1;
            overrun   <= rdy & ~rd_ack;
         end else if (rd_ack && rdy) begin
            rdy     <= 1'b0;
            overrun <= 1'b0;
         end
      end
   end

`ifdef UART_RX_PARITY_CHECK_EN
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)
         parity_err <= 1'b0;
      else if (complete)
         parity_err <= parity_error({par_bit, shift});
   end
`else
   assign parity_err = 1'b0;
`endif

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed plus randomized frames checked against a frame-level reference model.
module tb_uart_receiver;
   localparam int OS      = 16;
   localparam int DIV     = 4;
   localparam int BIT_CLK = OS * DIV;

   logic       clk    = 1'b0;
   logic       resetN = 1'b0;
   logic       rx     = 1'b1;
   logic       rx_en  = 1'b0;
   logic       rd_ack = 1'b0;
   logic [6:0] data_out;
   logic       valid, rdy, busy, parity_err, frame_err, overrun;

   int n_tests   = 0;
   int n_fail    = 0;
   int valid_cnt = 0;
   int busy_clks = 0;
   int div       = 0;

   // reference model of the holding register
   logic [6:0] exp_data = 7'd0;
   logic       exp_rdy  = 1'b0;
   logic       exp_ovr  = 1'b0;
   logic       exp_pe   = 1'b0;
   logic       exp_fe   = 1'b0;

   uart_receiver #(.OVERSAMPLE(OS), .CNT_W(4)) dut (
      .clk        (clk),
      .resetN     (resetN),
      .rx         (rx),
      .rx_en      (rx_en),
      .rd_ack     (rd_ack),
      .data_out   (data_out),
      .valid      (valid),
      .rdy        (rdy),
      .busy       (busy),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      div   = (div == DIV-1) ? 0 : div + 1;
      rx_en = (div == 0);
   end

   always @(negedge clk) begin
      if (valid) valid_cnt++;
      if (busy)  busy_clks++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_pe(input logic [6:0] d, input logic p);
`ifdef UART_RX_PARITY_CHECK_EN
      return (($countones({p, d}) % 2) == 0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic odd_par_bit(input logic [6:0] d);
      return (($countones(d) % 2) == 0);
   endfunction

   task automatic send_bits(input logic [9:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rx = bits[i];
         repeat (BIT_CLK-1) @(negedge clk);
      end
   endtask

   task automatic model_complete(input logic [6:0] d, input logic p, input logic stop);
      exp_ovr  = exp_rdy;
      exp_rdy  = 1'b1;
      exp_data = d;
      exp_pe   = model_pe(d, p);
      exp_fe   = !stop;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_data"}, 32'(data_out),   32'(exp_data));
      chk({tag, "_rdy"},  32'(rdy),        32'(exp_rdy));
      chk({tag, "_pe"},   32'(parity_err), 32'(exp_pe));
      chk({tag, "_fe"},   32'(frame_err),  32'(exp_fe));
      chk({tag, "_ovr"},  32'(overrun),    32'(exp_ovr));
   endtask

   task automatic frame_and_check(input string tag, input logic [6:0] d, input logic par_ok, input logic stop);
      logic p;
      int   v0;
      p  = par_ok ? odd_par_bit(d) : !odd_par_bit(d);
      v0 = valid_cnt;
      send_bits({stop, p, d, 1'b0}, 10);
      @(negedge clk);
      rx = 1'b1;
      repeat (15) @(negedge clk);
      #1;
      model_complete(d, p, stop);
      chk({tag, "_nvalid"}, 32'(valid_cnt - v0), 32'd1);
      check_outputs(tag);
   endtask

   task automatic ack();
      @(negedge clk);
      rd_ack = 1'b1;
      @(negedge clk);
      rd_ack = 1'b0;
      if (exp_rdy) begin
         exp_rdy = 1'b0;
         exp_ovr = 1'b0;
      end
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_data"},  32'(data_out),   32'd0);
      chk({tag, "_valid"}, 32'(valid),      32'd0);
      chk({tag, "_rdy"},   32'(rdy),        32'd0);
      chk({tag, "_busy"},  32'(busy),       32'd0);
      chk({tag, "_pe"},    32'(parity_err), 32'd0);
      chk({tag, "_fe"},    32'(frame_err),  32'd0);
      chk({tag, "_ovr"},   32'(overrun),    32'd0);
   endtask

   initial begin
      int         v0, b0, db;
      logic [6:0] d;
      logic [9:0] bits;

      repeat (3) @(negedge clk);
      #1;
      check_reset_values("reset");
      @(negedge clk);
      resetN = 1'b1;
      repeat (BIT_CLK) @(negedge clk);

      frame_and_check("h41_good", 7'h41, 1'b1, 1'b1);
      ack();
      chk("h41_ack_rdy", 32'(rdy), 32'(exp_rdy));

      frame_and_check("h41_badpar", 7'h41, 1'b0, 1'b1);
      ack();

      // bad stop bit, then the line stays low for 20 bit periods
      v0 = valid_cnt;
      d  = 7'h55;
      send_bits({1'b0, odd_par_bit(d), d, 1'b0}, 10);
      repeat (20*BIT_CLK) @(negedge clk);
      #1;
      model_complete(d, odd_par_bit(d), 1'b0);
      chk("stuck_nvalid", 32'(valid_cnt - v0), 32'd1);
      chk("stuck_busy", 32'(busy), 32'd0);
      check_outputs("h55_stop0");
      @(negedge clk);
      rx = 1'b1;
      repeat (BIT_CLK) @(negedge clk);
      ack();
      frame_and_check("h2A_after", 7'h2A, 1'b1, 1'b1);
      ack();

      // 4-tick glitch on an idle line
      repeat (BIT_CLK) @(negedge clk);
      v0 = valid_cnt;
      b0 = busy_clks;
      @(negedge clk);
      rx = 1'b0;
      repeat (4*DIV) @(negedge clk);
      rx = 1'b1;
      repeat (4*BIT_CLK) @(negedge clk);
      #1;
      db = busy_clks - b0;
      chk("glitch_nvalid", 32'(valid_cnt - v0), 32'd0);
      chk("glitch_busy_seen", 32'(db > 0), 32'd1);
      chk("glitch_busy_le8ticks", 32'(db <= 8*DIV), 32'd1);
      chk("glitch_idle", 32'(busy), 32'd0);

      frame_and_check("h11", 7'h11, 1'b1, 1'b1);
      frame_and_check("h22_ovr", 7'h22, 1'b1, 1'b1);
      ack();
      chk("ovr_ack_rdy", 32'(rdy), 32'd0);
      chk("ovr_ack_ovr", 32'(overrun), 32'd0);

      // reset during DATA bit 3
      v0   = valid_cnt;
      d    = 7'h33;
      bits = {1'b1, odd_par_bit(d), d, 1'b0};
      send_bits(bits, 4);
      @(negedge clk);
      rx = bits[4];
      repeat (20) @(negedge clk);
      chk("midframe_busy", 32'(busy), 32'd1);
      resetN = 1'b0;
      rx     = 1'b1;
      #1;
      check_reset_values("midreset");
      repeat (10) @(negedge clk);
      resetN  = 1'b1;
      exp_rdy = 1'b0;
      exp_ovr = 1'b0;
      repeat (BIT_CLK) @(negedge clk);
      #1;
      chk("aborted_nvalid", 32'(valid_cnt - v0), 32'd0);
      frame_and_check("h7F_after_reset", 7'h7F, 1'b1, 1'b1);
      ack();

      for (int k = 0; k < 8; k++) begin
         frame_and_check($sformatf("rand%0d", k), 7'($urandom),
                         1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
         if ($urandom_range(0, 1) == 1) ack();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel receive stage of the UART, the downstream peer of the transmitter. It recovers 7-bit characters from an asynchronous line framed as:

- 1 start bit (0)
- 7 data bits, LSB first
- 1 odd-parity bit
- 1 stop bit (1)

It samples the line on an oversampling enable from the shared baud generator. Each received character is presented on a holding register with a ready/acknowledge handshake, plus parity, framing and overrun status.

## Interface
Parameters:
- OVERSAMPLE, 16: rx_en ticks per bit period; even, ≥4.
- CNT_W, 4: width of the tick counter; must hold OVERSAMPLE-1.

Ports:
- clk  in  1  system clock.
- resetN  in  1  reset, asynchronous, active-low.
- rx  in  1  serial line, asynchronous to clk, idle high.
- rx_en  in  1  one-clk pulse at OVERSAMPLE × baud rate.
- rd_ack  in  1  consumer has taken data_out; one-clk pulse.
- data_out  out  7  last received character.
- valid  out  1  one-clk pulse when a frame completes.
- rdy  out  1  data_out holds an unread character.
- busy  out  1  a frame is in progress (state ≠ IDLE).
- parity_err  out  1  parity status of the character in data_out.
- frame_err  out  1  stop bit of that character sampled 0.
- overrun  out  1  a character was overwritten before rd_ack.

## Operation
- Input sync: rx passes through a 2-flop synchronizer, reset to 1. All decisions use the synchronized value rxs.
- Arm: an `armed` flag is set on any rx_en tick that sees rxs=1. A start is accepted only when armed=1, so a stuck-low line cannot retrigger reception. The flag clears when a start is accepted.
- State machine (tick counter cnt, bit index idx[2:0], 8-bit shift register). All transitions occur only on clk edges with rx_en=1:
  - IDLE: when armed and rxs=0, go to START with cnt=0.
  - START: cnt increments each tick.
    - At cnt=OVERSAMPLE/2-1 with rxs=0: go to DATA with cnt=0, idx=0.
    - At cnt=OVERSAMPLE/2-1 with rxs=1: false start; return to IDLE with armed=1.
  - DATA: at cnt=OVERSAMPLE-1, store rxs into shift[idx], then set cnt=0 and idx=idx+1. After storing idx=7 (the parity bit), go to STOP.
  - STOP: at cnt=OVERSAMPLE-1, do the completion actions below and return to IDLE.
- Completion (one clk):
  - data_out ← shift[6:0].
  - frame_err ← ~rxs.
  - parity_err ← ~^shift[7:0], i.e. the error is set when the total count of ones is even.
  - valid=1; rdy ← 1.
  - overrun ← 1 if rdy was already 1 and rd_ack=0 in that cycle.
- Handshake:
  - rd_ack while rdy=1 clears rdy and overrun on the next edge. rd_ack while rdy=0 is ignored.
  - If completion and rd_ack land in the same cycle, completion wins: rdy stays 1 and overrun stays 0.
- Overrun: the new character replaces data_out together with its error flags.
- Reset: asynchronous. Any state, including mid-frame, returns to IDLE, and the partial frame is discarded.

## Timing
- Reset values:
  - data_out=0, valid=0, rdy=0, busy=0, parity_err=0, frame_err=0, overrun=0.
  - Synchronizer=1, armed=0, state=IDLE, cnt=0, idx=0.
- Each bit is sampled at its midpoint, OVERSAMPLE/2 ticks after the detected falling edge (±1 tick of detection jitter). The rx-to-decision latency is 2 clk from synchronization.
- valid is high for exactly one clk: the cycle after the edge on which the stop-bit tick is processed. rdy, data_out and the error flags update on that same edge.
- busy rises on the edge that enters START. It falls on the edge that returns to IDLE, which coincides with valid rising.
- Nominal frame length is 10 bit periods; a new start is detectable immediately after the stop-bit sample.

## Configuration
- UART_RX_PARITY_CHECK_EN:
  - Defined: parity_err is computed as described in Operation.
  - Undefined: the parity logic is omitted and parity_err is constant 0. Bit 7 is still received and discarded, so the frame format is unchanged.

## Test plan
- Send 7'h41 with correct parity. Line sequence: 0,1,0,0,0,0,0,1,1,1. Expect a valid pulse, data_out=7'h41, rdy=1, and both error flags 0.
- Send 7'h41 with the parity bit inverted (0). Expect data_out=7'h41 and parity_err=1. If the macro is undefined, expect parity_err=0.
- Send 7'h55 with the stop bit forced 0, then hold rx low for 20 bit periods. Expect frame_err=1 and exactly one valid pulse. Release rx; a following 7'h2A frame is received cleanly.
- Drive a 4-tick low glitch on an idle line (OVERSAMPLE=16). Expect no valid; busy pulses high for ≤8 ticks, then the block returns to IDLE.
- Send 7'h11 then 7'h22 with no rd_ack. Expect overrun=1 and data_out=7'h22. A single rd_ack then clears both rdy and overrun.
- Assert resetN=0 during DATA bit 3 of a frame, then send 7'h7F. Expect all outputs at reset values during reset, no valid for the aborted frame, and then data_out=7'h7F.
